fifo_ctrl_asym: RTL
===================

// Module: fifo_ctrl_asym
// PURPOSE
//   Pointer/flag controller for the 2:1 asymmetric FIFO built on reg_file.
//   Each accepted write stores one 2*DATA_WIDTH word as two DATA_WIDTH entries.
//   Each accepted read pops one DATA_WIDTH entry, low half first.
//   Drives reg_file w_en/w_addr0/w_addr1/r_addr; owns occupancy, full and empty.
// PARAMETERS
//   ADDR_WIDTH  4  reg_file address width; DEPTH = 2**ADDR_WIDTH entries (narrow)
// PORTS
//   clk      in   1             rising-edge clock
//   reset_n  in   1             asynchronous, active-low reset
//   wr       in   1             write request (one wide word)
//   rd       in   1             read request (one narrow entry)
//   w_en     out  1             to reg_file w_en; = wr & ~full (combinational)
//   w_addr0  out  ADDR_WIDTH    low-half slot = wr_ptr
//   w_addr1  out  ADDR_WIDTH    high-half slot = wr_ptr+1 mod DEPTH
//   r_addr   out  ADDR_WIDTH    = rd_ptr; reg_file read data valid same cycle
//   empty    out  1             count == 0
//   full     out  1             count >= DEPTH-1 (fewer than 2 free slots)
//   count    out  ADDR_WIDTH+1  occupied narrow entries, 0..DEPTH
// BEHAVIOUR
//   State: wr_ptr, rd_ptr (ADDR_WIDTH bits each), count (ADDR_WIDTH+1 bits).
//   empty/full/w_en/addresses are combinational from state and wr; no extra latency.
//   Reset (async, reset_n=0): wr_ptr=0, rd_ptr=0, count=0 -> empty=1, full=0,
//     w_en=0 when wr=0, w_addr0=0, w_addr1=1, r_addr=0. Takes effect immediately,
//     including mid-operation; all in-flight data is discarded.
//   Accept rules (evaluated on pre-edge state; a read never frees space for a
//   same-cycle write, a write never supplies data for a same-cycle read):
//     wr_ok = wr & ~full;  rd_ok = rd & ~empty.
//   On posedge clk:
//     wr_ok  -> wr_ptr += 2 (mod DEPTH)
//     rd_ok  -> rd_ptr += 1 (mod DEPTH)
//     count  <= count + 2*wr_ok - rd_ok   (net +2, +1, -1 or 0)
//   Request while blocked: wr while full or rd while empty is silently dropped;
//     pointers and count unchanged; no error flag.
//   Wrap-around: wr_ptr always even (starts 0, steps 2), so w_addr1 = wr_ptr|1
//     and never wraps separately; rd_ptr wraps DEPTH-1 -> 0.
//   Ordering: word {H,L} written at wr_ptr=p reads out L (r_addr=p) then H (p+1).
//   Odd count is legal (one half consumed); full at count=DEPTH-1 blocks writes
//     until reads bring count to DEPTH-2 or below.
//   Simultaneous wr & rd when empty: write accepted, read dropped, count 0->2.
//   Simultaneous wr & rd when full: read accepted, write dropped, count -1.
//   Simultaneous wr & rd otherwise: both accepted, count +1.
//   Invariant: count == (wr_ptr - rd_ptr) mod DEPTH, except count==DEPTH
//     where the pointers are equal; bench checks this every cycle.
// TESTING  (ADDR_WIDTH=4, DEPTH=16, paired with reg_file DATA_WIDTH=8)
//   Reset: drop reset_n async mid-cycle -> empty=1, full=0, count=0,
//     w_addr0=0, w_addr1=1, r_addr=0 before the next clk edge.
//   Order: write 16'hBBAA, then rd x2 -> r_data 8'hAA then 8'hBB; empty=1 after.
//   Fill: 8 writes from empty -> count=16, full=1; 9th wr -> w_en=0, no change;
//     rd x1 -> count=15, full=1; rd x1 more -> count=14, full=0.
//   Wrap: 8 writes, 16 reads, 3 more writes -> w_addr0 sequence 0,2,..,14,0,2,4;
//     data read back in order across the wrap, no loss or duplication.
//   Simultaneous: wr&rd at count=0 -> count=2; at count=16 -> count=15;
//     at count=6 -> count=7; dropped rd at empty leaves rd_ptr unchanged.
//   Random: 10k cycles random wr/rd vs. scoreboard queue -> read data matches,
//     invariant holds, count never exceeds 16 or goes below 0.

Source files
------------

// File: rtl/fifo_ctrl_asym.sv
// Pointer and flag controller for a 2:1 asymmetric FIFO: one wide word in as two
// narrow reg_file entries, one narrow entry out per accepted read (low half first).
module fifo_ctrl_asym #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  w_en,
  output logic [ADDR_WIDTH-1:0] w_addr0,
  output logic [ADDR_WIDTH-1:0] w_addr1,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_TWO  = (ADDR_WIDTH+1)'(2);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_TWO  = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  wr_ok, rd_ok;

  // Full means fewer than two free slots, so a wide word always fits when accepted.
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q >= CNT_FULL);
    wr_ok   = wr & ~full;
    rd_ok   = rd & ~empty;
    w_en    = wr_ok;
    w_addr0 = wr_ptr_q;
    w_addr1 = wr_ptr_q + PTR_ONE;
    r_addr  = rd_ptr_q;
    count   = count_q;
  end

  always_comb begin
    wr_ptr_d = wr_ok ? wr_ptr_q + PTR_TWO : wr_ptr_q;
    rd_ptr_d = rd_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q + (wr_ok ? CNT_TWO : '0) - (rd_ok ? CNT_ONE : '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
